accum_sat_gear: RTL and testbench
=================================

# accum_sat_gear

Parametrised up/down accumulator with programmable saturation limits, sticky saturation flags, automatic step gear-shifting and a lock (dither) detector. It is the next-generation digital loop accumulator for calibration and tracking loops: it integrates signed step decisions from a comparator/phase detector, clamps exactly at programmable bounds instead of a coarse guard band, and speeds up coarse acquisition by left-shifting the step during long same-direction runs.

## Interface
Parameters:
- WIDTH, 16, accumulator width
- STEP_W, 4, step input width
- MAX_SHIFT, 3, maximum gear shift applied to step
- GEAR_CNT, 8, consecutive same-direction updates per gear-up (>=2)
- LOCK_CNT, 4, consecutive direction reversals that declare lock (>=2)
- RESET_VAL, 1<<(WIDTH-1), out value after reset (mid code)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstb  in  1  asynchronous, active-low reset
- enable  in  1  update qualifier; 0 = freeze all state
- up  in  1  direction: 1 = add, 0 = subtract
- step  in  STEP_W  unsigned base step
- sel_ext  in  1  load ext_val instead of integrating
- ext_val  in  WIDTH  external load value
- lo_lim  in  WIDTH  lower clamp bound (unsigned)
- hi_lim  in  WIDTH  upper clamp bound (unsigned)
- gear_en  in  1  enable gear-shifting
- clr_flags  in  1  clear sticky flags
- out  out  WIDTH  accumulator value; reset RESET_VAL
- sat_hi  out  1  sticky, upper clamp hit; reset 0
- sat_lo  out  1  sticky, lower clamp hit; reset 0
- shift  out  clog2(MAX_SHIFT+1)  current gear; reset 0
- locked  out  1  dither lock indicator; reset 0

## Operation
- Priority per edge: rstb low > enable=0 (hold everything) > sel_ext > integrate update.
- sel_ext=1 (enable=1): out <= ext_val verbatim (not clamped); shift, run counter, reversal counter, locked cleared; last_dir unchanged.
- Update = enable=1, sel_ext=0, step!=0, lo_lim<=hi_lim. step=0 or lo_lim>hi_lim: out and all counters hold.
- Effective step eff = step << shift, using the registered shift (pre-update value); computed at WIDTH+MAX_SHIFT+1 bits, no truncation.
- Up: if out+eff > hi_lim then out <= hi_lim, sat_hi set; else out <= out+eff.
- Down: if out < lo_lim+eff then out <= lo_lim, sat_lo set; else out <= out-eff. Comparisons are at extended width: no wrap-around ever.
- Sticky flags: clr_flags clears both; a set in the same cycle wins.
- Direction tracking: last_dir (reset = up) is updated on every update. A reversal is an update with up != last_dir.
- Gear (gear_en=1): same-direction update increments run counter; when it equals GEAR_CNT-1 at an update, run counter clears and shift increments (saturating at MAX_SHIFT). Reversal: shift decrements (floor 0), run counter clears. gear_en=0: shift and run counter forced to 0 on the next edge.
- Lock: reversal increments reversal counter (saturating at LOCK_CNT); same-direction update clears it and locked. locked=1 while counter == LOCK_CNT. Clamped updates count in their commanded direction.

## Timing
- Latency 1: inputs sampled at edge N drive out, flags, shift, locked after edge N.
- All outputs registered; no combinational input-to-output path.
- Gear/lock changes made at an update affect eff starting with the next update.
- rstb assertion mid-run: all outputs to reset values immediately (asynchronous). Deassertion is synchronised externally.

## Structure
- Shared package accum_pkg: clog2 function, direction constants DIR_UP/DIR_DN, default RESET_VAL helper.
- Sub-module accum_gear_ctrl: last_dir, run counter, shift, reversal counter, locked. Takes an update strobe, direction, gear_en and clear; outputs shift and locked. Top-level holds the datapath, clamping and flags.

## Test plan
Use WIDTH=16, STEP_W=4, MAX_SHIFT=3, GEAR_CNT=4, LOCK_CNT=4, lo_lim=0, hi_lim=0xFFFF unless stated.
- Reset: assert rstb mid-run -> out=0x8000, sat_hi=sat_lo=0, shift=0, locked=0 without a clock edge.
- Upper clamp: hi_lim=0xFFF0, load 0xFFEC, up step 8 -> out=0xFFF0, sat_hi=1; three more ups hold 0xFFF0; clr_flags -> sat_hi=0.
- Lower clamp: load 0x0005, down step 15 -> out=0x0000 (never 0xFFF6), sat_lo=1.
- Gear: gear_en=1, from 0x8000, 8 ups step 1 -> 0x8004 with shift=1 after 4th update, 0x800C with shift=2 after 8th; one down -> 0x8008, shift=1.
- Lock: gear_en=0, step 1, down/up/down/up -> locked=1 after 4th update, out=0x8000; next up -> locked=0.
- Precedence: enable=0 with sel_ext=1 -> no change; sel_ext=1 with up=1, ext_val=0x1234 -> out=0x1234, shift=0, locked=0; step=0 -> out holds.

Source files
------------

// File: rtl/accum_pkg.sv
// ============================================================================
// accum_pkg : shared helpers and constants for the accum_sat_gear slice
// Revision  : 1.0
// ============================================================================
`default_nettype none

package accum_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int field_w(input int max_val);
    int w;
    w = clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic longint unsigned mid_code(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/accum_gear_ctrl.sv
// ============================================================================
// accum_gear_ctrl : direction history, gear-shift and dither-lock tracking
// Revision        : 1.0
// ============================================================================
`default_nettype none

module accum_gear_ctrl
  import accum_pkg::*;
#(
  parameter int MAX_SHIFT = 3,
  parameter int GEAR_CNT  = 8,
  parameter int LOCK_CNT  = 4
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          i_en,
  input  logic                          i_upd,
  input  logic                          i_dir,
  input  logic                          i_gear_en,
  input  logic                          i_clr,
  output logic [field_w(MAX_SHIFT)-1:0] o_shift,
  output logic                          o_locked
);

  localparam int SHIFT_W = field_w(MAX_SHIFT);
  localparam int RUN_W   = field_w(GEAR_CNT - 1);
  localparam int REV_W   = field_w(LOCK_CNT);

  logic             r_last_dir;
  logic [RUN_W-1:0] r_run;
  logic [REV_W-1:0] r_rev;
  logic [SHIFT_W-1:0] r_shift;
  logic             r_locked;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_last_dir <= DIR_UP;
      r_run      <= '0;
      r_rev      <= '0;
      r_shift    <= '0;
      r_locked   <= 1'b0;
    end else if (i_clr) begin
      // External load restarts acquisition but keeps direction history.
      r_run    <= '0;
      r_rev    <= '0;
      r_shift  <= '0;
      r_locked <= 1'b0;
    end else begin
      if (i_upd) begin
        r_last_dir <= i_dir;
        if (i_dir == r_last_dir) begin
          r_rev    <= '0;
          r_locked <= 1'b0;
          if (i_gear_en) begin
            if (r_run == RUN_W'(GEAR_CNT - 1)) begin
              r_run <= '0;
              if (r_shift != SHIFT_W'(MAX_SHIFT))
                r_shift <= r_shift + SHIFT_W'(1);
            end else begin
              r_run <= r_run + RUN_W'(1);
            end
          end
        end else begin
          if (r_rev != REV_W'(LOCK_CNT))
            r_rev <= r_rev + REV_W'(1);
          r_locked <= (r_rev >= REV_W'(LOCK_CNT - 1));
          if (i_gear_en) begin
            r_run <= '0;
            if (r_shift != '0)
              r_shift <= r_shift - SHIFT_W'(1);
          end
        end
      end
      // Disabling gearing drops back to the base step on the next edge.
      if (i_en && !i_gear_en) begin
        r_run   <= '0;
        r_shift <= '0;
      end
    end
  end

  assign o_shift  = r_shift;
  assign o_locked = r_locked;

endmodule

`default_nettype wire

// File: rtl/accum_sat_gear.sv
// ============================================================================
// accum_sat_gear : clamped up/down loop accumulator with gear-shift and lock
// Revision       : 1.0
// ============================================================================
`default_nettype none

module accum_sat_gear
  import accum_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP_W    = 4,
  parameter int               MAX_SHIFT = 3,
  parameter int               GEAR_CNT  = 8,
  parameter int               LOCK_CNT  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(mid_code(WIDTH))
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          enable,
  input  logic                          up,
  input  logic [STEP_W-1:0]             step,
  input  logic                          sel_ext,
  input  logic [WIDTH-1:0]              ext_val,
  input  logic [WIDTH-1:0]              lo_lim,
  input  logic [WIDTH-1:0]              hi_lim,
  input  logic                          gear_en,
  input  logic                          clr_flags,
  output logic [WIDTH-1:0]              out,
  output logic                          sat_hi,
  output logic                          sat_lo,
  output logic [field_w(MAX_SHIFT)-1:0] shift,
  output logic                          locked
);

  localparam int SHIFT_W = field_w(MAX_SHIFT);
  localparam int EXT_W   = WIDTH + MAX_SHIFT + 1;

  logic [WIDTH-1:0]   r_out;
  logic               r_sat_hi;
  logic               r_sat_lo;
  logic [SHIFT_W-1:0] w_shift;
  logic               w_locked;

  logic               w_upd;
  logic [EXT_W-1:0]   w_eff;
  logic [EXT_W-1:0]   w_sum;
  logic [EXT_W-1:0]   w_floor;
  logic               w_over;
  logic               w_under;
  logic [WIDTH-1:0]   w_sum_lo;
  logic [WIDTH-1:0]   w_diff_lo;
  logic [WIDTH-1:0]   w_next;
  logic               w_set_hi;
  logic               w_set_lo;

  assign w_upd = enable && !sel_ext && (step != '0) && (lo_lim <= hi_lim);

  // Bounds are tested at extended width so neither direction can wrap.
  assign w_eff   = EXT_W'(step) << w_shift;
  assign w_sum   = EXT_W'(r_out) + w_eff;
  assign w_floor = EXT_W'(lo_lim) + w_eff;
  assign w_over  = w_sum > EXT_W'(hi_lim);
  assign w_under = EXT_W'(r_out) < w_floor;

  assign w_sum_lo  = r_out + w_eff[WIDTH-1:0];
  assign w_diff_lo = r_out - w_eff[WIDTH-1:0];

  always_comb begin
    w_next   = r_out;
    w_set_hi = 1'b0;
    w_set_lo = 1'b0;
    if (up) begin
      w_next   = w_over ? hi_lim : w_sum_lo;
      w_set_hi = w_upd && w_over;
    end else begin
      w_next   = w_under ? lo_lim : w_diff_lo;
      w_set_lo = w_upd && w_under;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_out    <= RESET_VAL;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else if (enable) begin
      if (sel_ext)
        r_out <= ext_val;
      else if (w_upd)
        r_out <= w_next;
      r_sat_hi <= w_set_hi || (r_sat_hi && !clr_flags);
      r_sat_lo <= w_set_lo || (r_sat_lo && !clr_flags);
    end
  end

  accum_gear_ctrl #(
    .MAX_SHIFT (MAX_SHIFT),
    .GEAR_CNT  (GEAR_CNT),
    .LOCK_CNT  (LOCK_CNT)
  ) u_gear_ctrl (
    .clk       (clk),
    .rstb      (rstb),
    .i_en      (enable),
    .i_upd     (w_upd),
    .i_dir     (up),
    .i_gear_en (gear_en),
    .i_clr     (enable && sel_ext),
    .o_shift   (w_shift),
    .o_locked  (w_locked)
  );

  assign out    = r_out;
  assign sat_hi = r_sat_hi;
  assign sat_lo = r_sat_lo;
  assign shift  = w_shift;
  assign locked = w_locked;

endmodule

`default_nettype wire

// File: tb/tb_accum_sat_gear.sv
// ============================================================================
// tb_accum_sat_gear : scoreboard bench with a behavioural accumulator model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_accum_sat_gear;

  localparam int GEAR = 4;
  localparam int LOCK = 4;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0;
  logic        up = 1'b1;
  logic [3:0]  step = '0;
  logic        sel_ext = 1'b0;
  logic [15:0] ext_val = '0;
  logic [15:0] lo_lim = 16'h0000;
  logic [15:0] hi_lim = 16'hFFFF;
  logic        gear_en = 1'b0;
  logic        clr_flags = 1'b0;
  logic [15:0] out;
  logic        sat_hi;
  logic        sat_lo;
  logic [1:0]  shift;
  logic        locked;

  accum_sat_gear #(
    .WIDTH     (16),
    .STEP_W    (4),
    .MAX_SHIFT (MAXS),
    .GEAR_CNT  (GEAR),
    .LOCK_CNT  (LOCK)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .enable    (enable),
    .up        (up),
    .step      (step),
    .sel_ext   (sel_ext),
    .ext_val   (ext_val),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .gear_en   (gear_en),
    .clr_flags (clr_flags),
    .out       (out),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo),
    .shift     (shift),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] out;
    bit          hi;
    bit          lo;
    logic [1:0]  sh;
    bit          lk;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state kept as plain integers.
  int m_out, m_shift, m_run, m_rev;
  bit m_last_up, m_lock, m_shi, m_slo;

  function automatic void model_reset();
    m_out = 32'h8000; m_shift = 0; m_run = 0; m_rev = 0;
    m_last_up = 1; m_lock = 0; m_shi = 0; m_slo = 0;
  endfunction

  function automatic void compare(exp_t e);
    n_checks++;
    if (out !== e.out || sat_hi !== e.hi || sat_lo !== e.lo ||
        shift !== e.sh || locked !== e.lk) begin
      n_errors++;
      $display("FAIL %s: got out=%h hi=%b lo=%b shift=%0d locked=%b, want out=%h hi=%b lo=%b shift=%0d locked=%b",
               e.name, out, sat_hi, sat_lo, shift, locked, e.out, e.hi, e.lo, e.sh, e.lk);
    end
  endfunction

  function automatic exp_t model_snapshot(string name);
    exp_t e;
    e.name = name; e.out = 16'(m_out); e.hi = m_shi; e.lo = m_slo;
    e.sh = 2'(m_shift); e.lk = m_lock;
    return e;
  endfunction

  function automatic void model_step(bit en, bit sel, bit u, int st, int ev,
                                     int lo, int hi, bit ge, bit clr);
    int eff;
    bit set_hi, set_lo;
    set_hi = 0; set_lo = 0;
    if (!en) return;
    if (sel) begin
      m_out = ev; m_shift = 0; m_run = 0; m_rev = 0; m_lock = 0;
    end else if (st != 0 && lo <= hi) begin
      eff = st << m_shift;
      if (u) begin
        if (m_out + eff > hi) begin m_out = hi; set_hi = 1; end
        else m_out = m_out + eff;
      end else begin
        if (m_out < lo + eff) begin m_out = lo; set_lo = 1; end
        else m_out = m_out - eff;
      end
      if (u == m_last_up) begin
        m_rev = 0; m_lock = 0;
        if (ge) begin
          if (m_run == GEAR - 1) begin
            m_run = 0;
            if (m_shift < MAXS) m_shift++;
          end else m_run++;
        end
      end else begin
        if (m_rev < LOCK) m_rev++;
        m_lock = (m_rev == LOCK);
        if (ge) begin
          m_run = 0;
          if (m_shift > 0) m_shift--;
        end
      end
      m_last_up = u;
    end
    if (!ge) begin m_shift = 0; m_run = 0; end
    m_shi = set_hi | (m_shi & ~clr);
    m_slo = set_lo | (m_slo & ~clr);
  endfunction

  task automatic drive(string name, bit en, bit sel, bit u, logic [3:0] st,
                       logic [15:0] ev, logic [15:0] lo, logic [15:0] hi,
                       bit ge, bit clr);
    @(negedge clk);
    enable = en; sel_ext = sel; up = u; step = st; ext_val = ev;
    lo_lim = lo; hi_lim = hi; gear_en = ge; clr_flags = clr;
    model_step(en, sel, u, int'(st), int'(ev), int'(lo), int'(hi), ge, clr);
    q.push_back(model_snapshot(name));
  endtask

  // Asynchronous reset asserted mid-cycle and checked before any rising edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    model_reset();
    compare(model_snapshot("async_reset"));
    enable = 1'b0; sel_ext = 1'b0; clr_flags = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) compare(q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare(model_snapshot("reset_state"));
    rstb = 1'b1;

    // Upper clamp and flag clear.
    drive("hi_load",  1, 1, 1, 4'd0, 16'hFFEC, 16'h0000, 16'hFFF0, 0, 0);
    drive("hi_clamp", 1, 0, 1, 4'd8, 16'h0000, 16'h0000, 16'hFFF0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("hi_hold", 1, 0, 1, 4'd8, 16'h0000, 16'h0000, 16'hFFF0, 0, 0);
    drive("hi_clr",   1, 0, 1, 4'd0, 16'h0000, 16'h0000, 16'hFFF0, 0, 1);

    // Lower clamp must not wrap.
    drive("lo_load",  1, 1, 0, 4'd0,  16'h0005, 16'h0000, 16'hFFFF, 0, 0);
    drive("lo_clamp", 1, 0, 0, 4'd15, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);

    // Gear acquisition from mid code.
    mid_reset();
    for (int i = 0; i < 8; i++)
      drive("gear_up", 1, 0, 1, 4'd1, 16'h0000, 16'h0000, 16'hFFFF, 1, 0);
    drive("gear_down", 1, 0, 0, 4'd1, 16'h0000, 16'h0000, 16'hFFFF, 1, 0);

    // Dither lock.
    mid_reset();
    for (int i = 0; i < 4; i++)
      drive("lock_dither", 1, 0, (i % 2 == 1), 4'd1, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
    drive("lock_break", 1, 0, 1, 4'd1, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);

    // Precedence.
    drive("prec_frozen", 0, 1, 1, 4'd3, 16'h1234, 16'h0000, 16'hFFFF, 1, 1);
    drive("prec_load",   1, 1, 1, 4'd3, 16'h1234, 16'h0000, 16'hFFFF, 1, 0);
    drive("prec_step0",  1, 0, 1, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0);
    drive("prec_badlim", 1, 0, 1, 4'd5, 16'h0000, 16'h9000, 16'h8000, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] lo, hi;
      if ($urandom_range(0, 7) == 0) begin
        lo = 16'($urandom); hi = 16'($urandom);
      end else begin
        lo = 16'($urandom_range(0, 16'h4000));
        hi = 16'($urandom_range(16'hB000, 16'hFFFF));
      end
      drive("random",
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 19) == 0,
            1'($urandom),
            4'($urandom),
            16'($urandom),
            lo, hi,
            $urandom_range(0, 4) != 0,
            $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
